// File: rtl/mmc1_sync.sv
// MMC1-style mapper with all CPU-side inputs resynchronised into the SYS_CLK domain.
// Define MMC1_SUROM_EN to widen PRG_A by one bit, driven from CHR bank bit 4 (SUROM 512K PRG).
module mmc1_sync #(
  parameter int PRG_AW = 4,
  parameter int CHR_AW = 5
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              CPU_M2,
  input  logic              nCPU_ROMSEL,
  input  logic              nCPU_RW,
  input  logic              CPU_A13,
  input  logic              CPU_A14,
  input  logic              CPU_D0,
  input  logic              CPU_D7,
  input  logic              PPU_A10,
  input  logic              PPU_A11,
  input  logic              PPU_A12,
  output logic              CIRAM_A10,
`ifdef MMC1_SUROM_EN
  output logic [PRG_AW:0]   PRG_A,
`else
  output logic [PRG_AW-1:0] PRG_A,
`endif
  output logic [CHR_AW-1:0] CHR_A,
  output logic              nPRG_CE,
  output logic              nWRAM_CE
);

  localparam int S_D0 = 0, S_D7 = 1, S_A13 = 2, S_A14 = 3, S_RW = 4, S_ROMSEL = 5, S_M2 = 6;
  localparam int C_RW = 0, C_ROMSEL = 1, C_D7 = 2, C_D0 = 3, C_A13 = 4, C_A14 = 5;

  logic [6:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [5:0] cap_q, cap_d;
  logic       m2_prev_q, m2_prev_d;
  logic       wr_prev_q, wr_prev_d;
  logic [4:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;

  logic       m2_fall;
  logic       wr_event;
  logic       wr_accept;
  logic [4:0] commit_val;

  assign m2_fall    = m2_prev_q & ~sync2_q[S_M2];
  assign wr_event   = m2_fall & ~cap_q[C_ROMSEL] & ~cap_q[C_RW];
  assign wr_accept  = wr_event & ~wr_prev_q;
  assign commit_val = {cap_q[C_D0], shift_q[4:1]};

  always_comb begin
    sync1_d   = {CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0};
    sync2_d   = sync1_q;
    m2_prev_d = sync2_q[S_M2];
    cap_d     = cap_q;
    wr_prev_d = wr_prev_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;

    if (sync2_q[S_M2]) begin
      cap_d = {sync2_q[S_A14], sync2_q[S_A13], sync2_q[S_D0], sync2_q[S_D7],
               sync2_q[S_ROMSEL], sync2_q[S_RW]};
    end

    // The filter flag tracks every fall, so a discarded write still keeps it set.
    if (m2_fall) begin
      wr_prev_d = wr_event;
    end

    if (wr_accept) begin
      if (cap_q[C_D7]) begin
        shift_d     = 5'd0;
        cnt_d       = 3'd0;
        ctrl_d[3:2] = 2'b11;
      end else if (cnt_q == 3'd4) begin
        shift_d = 5'd0;
        cnt_d   = 3'd0;
        unique case ({cap_q[C_A14], cap_q[C_A13]})
          2'b00:   ctrl_d = commit_val;
          2'b01:   chr0_d = commit_val;
          2'b10:   chr1_d = commit_val;
          default: prg_d  = commit_val;
        endcase
      end else begin
        shift_d = {cap_q[C_D0], shift_q[4:1]};
        cnt_d   = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      sync1_q   <= 7'd0;
      sync2_q   <= 7'd0;
      m2_prev_q <= 1'b0;
      cap_q     <= 6'd0;
      wr_prev_q <= 1'b0;
      shift_q   <= 5'd0;
      cnt_q     <= 3'd0;
      ctrl_q    <= 5'b01100;
      chr0_q    <= 5'd0;
      chr1_q    <= 5'd0;
      prg_q     <= 5'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      m2_prev_q <= m2_prev_d;
      cap_q     <= cap_d;
      wr_prev_q <= wr_prev_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
    end
  end

  logic [PRG_AW-1:0] prg_lo;
  logic [CHR_AW-1:0] chr_lo;

  always_comb begin
    unique case (ctrl_q[1:0])
      2'b00:   CIRAM_A10 = 1'b0;
      2'b01:   CIRAM_A10 = 1'b1;
      2'b10:   CIRAM_A10 = PPU_A10;
      default: CIRAM_A10 = PPU_A11;
    endcase

    // Overwriting bit 0 keeps the 32K mode valid for any PRG_AW, including 1.
    prg_lo = prg_q[PRG_AW-1:0];
    unique case (ctrl_q[3:2])
      2'b10:   prg_lo = CPU_A14 ? prg_q[PRG_AW-1:0] : '0;
      2'b11:   prg_lo = CPU_A14 ? '1 : prg_q[PRG_AW-1:0];
      default: prg_lo[0] = CPU_A14;
    endcase

    chr_lo = chr0_q[CHR_AW-1:0];
    if (ctrl_q[4]) begin
      chr_lo = PPU_A12 ? chr1_q[CHR_AW-1:0] : chr0_q[CHR_AW-1:0];
    end else begin
      chr_lo[0] = PPU_A12;
    end
  end

`ifdef MMC1_SUROM_EN
  logic surom_msb;
  assign surom_msb = (ctrl_q[4] & PPU_A12) ? chr1_q[4] : chr0_q[4];
  assign PRG_A     = {surom_msb, prg_lo};
`else
  assign PRG_A     = prg_lo;
`endif

  assign CHR_A    = chr_lo;
  assign nPRG_CE  = nCPU_ROMSEL | ~nCPU_RW;
  assign nWRAM_CE = ~(nCPU_ROMSEL & CPU_M2 & CPU_A14 & CPU_A13 & ~prg_q[4]);

endmodule
